paramdeser: RTL and testbench

//  Serial-in / parallel-out receiver: the far end of the paramreg shift register.
//  - Collects a serial bit stream, one bit per qualified clock, into a WIDTH-bit word.
//  - Supports MSB-first or LSB-first bit order.
//  - Presents each completed word on a one-entry output buffer with a valid/ready handshake.
//  - Reports overrun when a word completes while the buffer is still occupied.

---
 rtl/paramdeser.sv | 128 ++++++++++++
 tb/tb_paramdeser.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/paramdeser.sv
// Serial-in / parallel-out receiver with a one-entry valid/ready output buffer.
// Bit order is latched per frame; a word completing into a full buffer is dropped and flagged.
module paramdeser #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sin,
    input  logic             sen,
    input  logic             msb_first,
    output logic [WIDTH-1:0] Q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   sr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               order_q;
    logic [WIDTH-1:0]   q_q;
    logic               valid_q;
    logic               ovr_q;
    logic               busy_q;

    logic               order_d;
    logic [WIDTH-1:0]   sr_d;
    logic               take_d;
    logic               last_d;

    // Next shift-register value; the first bit of a frame uses the live order input.
    always_comb begin
        order_d = order_q;
        sr_d    = sr_q;
        if (state_q == S_IDLE) begin
            order_d = msb_first;
        end else begin
            order_d = order_q;
        end
        if (order_d) begin
            sr_d = {sr_q[WIDTH-2:0], sin};
        end else begin
            sr_d = {sin, sr_q[WIDTH-1:1]};
        end
    end

    // clr wins over sen, so a discarded bit never advances or completes a frame.
    assign take_d = sen & ~clr;
    assign last_d = take_d && (state_q == S_SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

    // Receive FSM plus output buffer, overrun flag and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            order_q <= 1'b0;
            q_q     <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (clr) begin
                state_q <= S_IDLE;
                cnt_q   <= {CNT_W{1'b0}};
                busy_q  <= 1'b0;
                ovr_q   <= 1'b0;
            end else if (take_d) begin
                sr_q <= sr_d;
                case (state_q)
                    S_IDLE: begin
                        order_q <= order_d;
                        cnt_q   <= CNT_W'(1);
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (last_d) begin
                            cnt_q   <= {CNT_W{1'b0}};
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                            busy_q  <= 1'b1;
                        end
                    end
                    default: begin
                        cnt_q   <= {CNT_W{1'b0}};
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end else begin
                state_q <= state_q;
            end

            // A completing word may replace a word being accepted on the same edge.
            if (last_d) begin
                if (!valid_q || q_ready) begin
                    q_q     <= sr_d;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q   <= 1'b1;
                end
            end else if (valid_q && q_ready) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_q;
            end
        end
    end

    assign Q       = q_q;
    assign q_valid = valid_q;
    assign overrun = ovr_q;
    assign busy    = busy_q;
    assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_paramdeser.sv
// Randomized bench for paramdeser: a bit-queue reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_paramdeser;
    localparam int W  = 12;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr, sin, sen, msb_first, q_ready;
    logic [W-1:0]  Q;
    logic          q_valid, busy, overrun;
    logic [CW-1:0] bit_cnt;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // reference model state
    bit           m_bits[$];
    bit           m_ord;
    logic [W-1:0] m_q;
    bit           m_valid;
    bit           m_ovr;

    paramdeser #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .sin(sin), .sen(sen), .msb_first(msb_first),
        .Q(Q), .q_valid(q_valid), .q_ready(q_ready), .busy(busy), .bit_cnt(bit_cnt),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_ord   = 1'b0;
        m_q     = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Applies one clock edge to the model from the current inputs.
    task automatic model_edge();
        bit           done;
        logic [W-1:0] w;
        done = 1'b0;
        w    = '0;
        if (clr) begin
            m_bits.delete();
            m_ovr = 1'b0;
        end else if (sen) begin
            if (m_bits.size() == 0) m_ord = msb_first;
            m_bits.push_back(sin);
            if (m_bits.size() == W) begin
                done = 1'b1;
                for (int i = 0; i < W; i++) begin
                    if (m_ord) w[W-1-i] = m_bits[i];
                    else       w[i]     = m_bits[i];
                end
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || q_ready) begin
                m_q     = w;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && q_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("Q", 32'(Q), 32'(m_q));
            chk("q_valid", 32'(q_valid), 32'(m_valid));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
            chk("busy", 32'(busy), 32'(m_bits.size() != 0));
        end
    end

    task automatic cyc(input logic s, input logic e, input logic c, input logic r, input logic m);
        sin = s; sen = e; clr = c; q_ready = r; msb_first = m;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic ord, input int gap_pct,
                             input logic rdy, input logic last_rdy, input bit tog);
        logic m;
        int   idx;
        int   gaps;
        m = ord;
        for (int i = 0; i < W; i++) begin
            idx  = ord ? (W - 1 - i) : i;
            gaps = 0;
            while (gaps < 4 && $urandom_range(99) < gap_pct) begin
                cyc(1'($urandom_range(1)), 1'b0, 1'b0, rdy, m);
                gaps++;
            end
            if (tog && i == 4) m = ~m;
            cyc(w[idx], 1'b1, 1'b0, (i == W - 1) ? last_rdy : rdy, m);
        end
    endtask

    task automatic accept();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; sin = 1'b0; sen = 1'b0; msb_first = 1'b0; q_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_Q", 32'(Q), 32'h0);
        chk("rst_valid", 32'(q_valid), 32'h0);
        chk("rst_cnt", 32'(bit_cnt), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // 1: MSB-first, back-to-back bits
        send_word(12'd55, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("t1_Q", 32'(Q), 32'h037);
        chk("t1_valid", 32'(q_valid), 32'h1);
        accept();
        chk("t1_accept", 32'(q_valid), 32'h0);

        // 2: LSB-first with gaps, order input toggled mid-frame
        send_word(12'd55, 1'b0, 40, 1'b0, 1'b0, 1'b1);
        chk("t2_Q", 32'(Q), 32'h037);
        chk("t2_valid", 32'(q_valid), 32'h1);
        accept();

        // 3: overrun, then clr
        send_word(12'hABC, 1'b1, 20, 1'b0, 1'b0, 1'b0);
        send_word(12'h123, 1'b1, 20, 1'b0, 1'b0, 1'b0);
        chk("t3_Q", 32'(Q), 32'hABC);
        chk("t3_ovr", 32'(overrun), 32'h1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_clr_ovr", 32'(overrun), 32'h0);
        chk("t3_clr_Q", 32'(Q), 32'hABC);
        chk("t3_clr_valid", 32'(q_valid), 32'h1);

        // 4: accept on the same edge that completes a new word
        send_word(12'h5A5, 1'b1, 20, 1'b0, 1'b1, 1'b0);
        chk("t4_Q", 32'(Q), 32'h5A5);
        chk("t4_valid", 32'(q_valid), 32'h1);
        chk("t4_ovr", 32'(overrun), 32'h0);
        accept();

        // 5: abort mid-frame, clr beating sen
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t5_cnt5", 32'(bit_cnt), 32'h5);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_cnt", 32'(bit_cnt), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        send_word(12'hFFF, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("t5_Q", 32'(Q), 32'hFFF);
        accept();

        // 6: asynchronous reset between edges after 7 bits
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        sen = 1'b0; clr = 1'b0; q_ready = 1'b0;
        @(posedge clk);
        model_edge();
        #2 rst = 1'b1;
        #1;
        chk("t6_cnt", 32'(bit_cnt), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_Q", 32'(Q), 32'h0);
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        send_word(12'd55, 1'b1, 30, 1'b0, 1'b0, 1'b0);
        chk("t6_Q55", 32'(Q), 32'h037);
        accept();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            cyc(1'($urandom_range(1)), 1'($urandom_range(99) < 60),
                1'($urandom_range(99) < 2), 1'($urandom_range(99) < 40),
                1'($urandom_range(1)));
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
